count_stamp: RTL and testbench

Timestamp capture stage downstream of the 32-bit free-running `counter`. On each rising edge of a synchronous event strobe, the current counter value `q` is written into a small FIFO. Timestamps are presented to the consumer on a valid/ready interface in first-word-fall-through order. Overflow drops new stamps; it never overwrites stored ones.

---
 rtl/count_stamp.sv | 163 ++++++++++++++++
 tb/tb_count_stamp.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_stamp.sv
`default_nettype none
// ============================================================================
// Module   : count_stamp
// Purpose  : Timestamp capture FIFO. On each rising edge of the synchronous
//            event strobe the current 32-bit counter value is pushed into a
//            small first-word-fall-through FIFO and offered to the consumer on
//            a valid/ready interface. When the FIFO is full, new stamps are
//            dropped. Stored stamps are never overwritten.
// Ports    : clk        - single clock, rising edge
//            reset      - synchronous, active-high
//            q[31:0]    - counter value, sampled on capture
//            event_in   - event strobe, synchronous to clk
//            out_valid  - head entry available
//            out_ready  - consumer accepts head when high with out_valid
//            out_data   - head timestamp (don't-care when out_valid = 0)
//            level      - stored entries, 0..DEPTH
//            full       - level == DEPTH
//            overflow   - sticky: a capture was dropped since reset
//            drop_cnt   - saturating dropped-capture count (optional)
// Options  : COUNT_STAMP_DROP_CNT_EN - adds the drop_cnt port and counter
// Revision : 1.0 - initial release
// ============================================================================
module count_stamp #(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   q,
   input  logic          event_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_data,
   output logic [AW:0]   level,
   output logic          full,
   output logic          overflow
`ifdef COUNT_STAMP_DROP_CNT_EN
   ,
   output logic [15:0]   drop_cnt
`endif
);

   localparam logic [AW:0]   c_full_level = (AW+1)'(DEPTH);
   localparam logic [AW:0]   c_level_one  = (AW+1)'(1);
   localparam logic [AW-1:0] c_ptr_one    = AW'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          r_evt_d;
   logic          r_overflow;

   // ------------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------------
   logic w_rise;
   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_rise  = event_in & ~r_evt_d;
   assign w_full  = (r_level == c_full_level);
   assign w_empty = (r_level == '0);
   // A pop on an empty FIFO is meaningless, so it is masked here.
   assign w_pop   = out_ready & ~w_empty;
   // A simultaneous pop frees the slot the push needs, so a full FIFO
   // still accepts the capture in that cycle.
   assign w_push  = w_rise & (~w_full | w_pop);
   assign w_drop  = w_rise & w_full & ~w_pop;

   // ------------------------------------------------------------------------
   // Edge detector. Held at 1 in reset so a strobe that is already high when
   // reset releases is not taken as a new event.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_evt_d <= 1'b1;
      end else begin
         r_evt_d <= event_in;
      end
   end

   // ------------------------------------------------------------------------
   // Storage. Contents are intentionally not reset; reset only empties the
   // FIFO through the pointers and level.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_mem[r_wr_ptr] <= q;
      end
   end

   // ------------------------------------------------------------------------
   // Pointers and occupancy. Pointers wrap naturally at DEPTH because DEPTH
   // is a power of two; level carries the extra bit to tell full from empty.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_level_one;
            2'b01:   r_level <= r_level - c_level_one;
            default: r_level <= r_level;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Sticky overflow flag
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

`ifdef COUNT_STAMP_DROP_CNT_EN
   // ------------------------------------------------------------------------
   // Dropped-capture counter, saturating at all-ones so a long overflow
   // episode never reads back as a small count.
   // ------------------------------------------------------------------------
   logic [15:0] r_drop_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_drop_cnt <= '0;
      end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

   // ------------------------------------------------------------------------
   // Outputs: all derived from registered state, no path from event_in or
   // out_ready.
   // ------------------------------------------------------------------------
   assign out_data  = r_mem[r_rd_ptr];
   assign out_valid = ~w_empty;
   assign level     = r_level;
   assign full      = w_full;
   assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_count_stamp.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_stamp
// Purpose  : Self-checking bench for count_stamp. Directed stimulus pushes the
//            stamps it expects to be captured into a scoreboard queue; a
//            monitor pops and compares on every accepted handshake. Status
//            outputs are compared directly against hand-derived values.
// Options  : COUNT_STAMP_DROP_CNT_EN - also checks drop_cnt
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_stamp;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] q;
   logic        event_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  level;
   logic        full;
   logic        overflow;
`ifdef COUNT_STAMP_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   count_stamp #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .q         (q),
      .event_in  (event_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level),
      .full      (full),
      .overflow  (overflow)
`ifdef COUNT_STAMP_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] sb [$];
   logic [31:0] mon_exp;

   // Free-running counter model feeding q; cleared by the same reset.
   initial q = 32'd0;
   always @(posedge clk) begin
      #1;
      if (reset) q = 32'd0;
      else       q = q + 32'd1;
   end

   // Monitor: samples on the falling edge; a handshake seen here is the one
   // the DUT accepts on the next rising edge.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         n_total++;
         if (sb.size() == 0) begin
            $display("FAIL pop_unexpected: out_data=%0d, required no entry", out_data);
         end else begin
            mon_exp = sb.pop_front();
            if (out_data === mon_exp) n_pass++;
            else $display("FAIL pop_data: out_data=%0d, required %0d", out_data, mon_exp);
         end
      end
   end

   // Inputs change 2 time units after the rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   task automatic wait_q(input logic [31:0] target);
      int n = 0;
      while (q != target && n < 1000) begin
         step(1);
         n++;
      end
      chk("wait_q", q, target);
   endtask

   // One-cycle strobe followed by one low cycle.
   task automatic pulse(input bit captured);
      event_in = 1'b1;
      if (captured) sb.push_back(q);
      step(1);
      event_in = 1'b0;
      step(1);
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while (level != 0 && n < 4 * DEPTH) begin
         step(1);
         n++;
      end
      out_ready = 1'b0;
      step(1);
      chk("drain_level", level, 0);
      chk("drain_sb_empty", sb.size(), 0);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      sb.delete();
      step(n);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal end");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      event_in  = 1'b0;
      out_ready = 1'b0;
      step(3);
      chk("rst_level", level, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_full", full, 0);
      chk("rst_overflow", overflow, 0);
`ifdef COUNT_STAMP_DROP_CNT_EN
      chk("rst_drop_cnt", drop_cnt, 0);
`endif
      reset = 1'b0;

      // Single capture with one-cycle latency.
      wait_q(32'd10);
      event_in = 1'b1;
      sb.push_back(q);
      step(1);
      event_in = 1'b0;
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 10);
      chk("single_level", level, 1);
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      chk("single_pop_level", level, 0);
      chk("single_pop_valid", out_valid, 0);

      // Held level captures once, the value from the first high cycle.
      event_in = 1'b1;
      sb.push_back(q);
      step(20);
      event_in = 1'b0;
      step(1);
      chk("held_level", level, 1);
      drain();

      // Ordering: 8 stamps 20, 22, ..., 34.
      do_reset(1);
      wait_q(32'd20);
      for (int i = 0; i < DEPTH; i++) pulse(1'b1);
      chk("fill_full", full, 1);
      chk("fill_level", level, 8);
      chk("fill_overflow", overflow, 0);
      drain();

      // Move pointers off zero so the next fill crosses the wrap.
      for (int i = 0; i < 3; i++) pulse(1'b1);
      drain();
      for (int i = 0; i < DEPTH; i++) pulse(1'b1);
      chk("wrap_full", full, 1);

      // Overflow: three more pulses are dropped.
      for (int i = 0; i < 3; i++) pulse(1'b0);
      chk("ovf_flag", overflow, 1);
      chk("ovf_level", level, 8);
`ifdef COUNT_STAMP_DROP_CNT_EN
      chk("ovf_drop_cnt", drop_cnt, 3);
`endif
      drain();

      // Simultaneous push and pop while full.
      for (int i = 0; i < DEPTH; i++) pulse(1'b1);
      chk("simul_pre_full", full, 1);
      event_in  = 1'b1;
      out_ready = 1'b1;
      sb.push_back(q);
      step(1);
      event_in  = 1'b0;
      out_ready = 1'b0;
      chk("simul_level", level, 8);
`ifdef COUNT_STAMP_DROP_CNT_EN
      chk("simul_drop_cnt", drop_cnt, 3);
`endif
      step(1);
      drain();

      // Reset mid-operation with event_in high.
      for (int i = 0; i < 5; i++) pulse(1'b1);
      chk("pre_rst_level", level, 5);
      event_in = 1'b1;
      do_reset(1);
      chk("midrst_level", level, 0);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_overflow", overflow, 0);
      chk("midrst_full", full, 0);
`ifdef COUNT_STAMP_DROP_CNT_EN
      chk("midrst_drop_cnt", drop_cnt, 0);
`endif
      step(3);
      chk("held_after_rst_level", level, 0);
      event_in = 1'b0;
      step(1);

      // Capture still works after the held strobe is released.
      pulse(1'b1);
      chk("post_rst_level", level, 1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
